// File: rtl/div_radix2.sv
// Radix-2 restoring divider for DIV/DIVU: WIDTH+2 cycles start-to-idle (valid in cycle WIDTH+1), 2 for divide-by-zero.
// start is ignored while busy; cancel aborts without valid and leaves quotient/remainder untouched.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dvd, dvs, q;
    // Partial remainder is always below the divisor, so its top bit lives only in shifted/trial.
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             neg_q, neg_r;
    logic             b_zero, last;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] q_step, r_step, a_mag, b_mag;

    assign b_zero  = (b == '0);
    assign last    = (count == CW'(WIDTH - 1));
    assign a_mag   = (signed_div && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (signed_div && b[WIDTH-1]) ? -b : b;
    assign shifted = {rem, dvd[WIDTH-1]};
    assign trial   = shifted + {1'b1, ~dvs} + (WIDTH+1)'(1);
    assign q_step  = {q[WIDTH-2:0], ~trial[WIDTH]};
    assign r_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

    assign busy  = (state != IDLE);
    assign valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = b_zero ? DONE : DIV;
            DIV:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cancel) state_nxt = IDLE;
    end

    // Results are loaded on the edge into DONE so they are final in the valid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd       <= '0;
            dvs       <= '0;
            q         <= '0;
            rem       <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (!cancel) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b_zero) begin
                            quotient  <= '1;
                            remainder <= a;
                        end else begin
                            dvd   <= a_mag;
                            dvs   <= b_mag;
                            neg_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r <= signed_div & a[WIDTH-1];
                            rem   <= '0;
                            q     <= '0;
                            count <= '0;
                        end
                    end
                end
                DIV: begin
                    rem   <= r_step;
                    q     <= q_step;
                    dvd   <= {dvd[WIDTH-2:0], 1'b0};
                    count <= count + CW'(1);
                    if (last) begin
                        quotient  <= neg_q ? -q_step : q_step;
                        remainder <= neg_r ? -r_step : r_step;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
